// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchronizer, per-state baud counter, bit
// counter, LSB-first shift register and a five-state FSM. Frame configuration
// (data-bit count, stop-bit count, baud divisor) is captured at the start of
// each frame and held until the frame completes or is aborted.
module uart_rx #(
  parameter int DATA_WIDTH             = 8,
  parameter int BAUD_GEN_CNTER_MAX_VAL = 512,
  parameter int BAUD_GEN_CNTER_WIDTH   = $clog2(BAUD_GEN_CNTER_MAX_VAL)
) (
  input  logic                            clk_i,
  input  logic                            s_rst_n_i,
  input  logic                            enable_i,
  input  logic                            rx_i,
  input  logic                            data_bit_num_i,
  input  logic                            stop_bit_num_i,
  input  logic [BAUD_GEN_CNTER_WIDTH-1:0] baud_tick_val_i,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic                            data_valid_o,
  output logic                            frame_err_o,
  output logic                            busy_o
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                          state, state_next;
  logic                            rx_meta, rx_s;
  logic [BAUD_GEN_CNTER_WIDTH-1:0] baud_cnt;
  logic [BAUD_GEN_CNTER_WIDTH-1:0] tick_q;
  logic                            full_bits_q;
  logic                            two_stop_q;
  logic [BIT_CNT_W-1:0]            bit_cnt;
  logic [BIT_CNT_W-1:0]            last_data_idx;
  logic [BIT_CNT_W-1:0]            last_stop_idx;
  logic [DATA_WIDTH-1:0]           shreg;
  logic                            err_q;
  logic                            baud_mid, baud_end;
  logic                            start_frame, data_sample, stop_sample, frame_done;
  logic                            frame_bad;

  assign baud_mid      = (baud_cnt == (tick_q >> 1));
  assign baud_end      = (baud_cnt == tick_q);
  assign last_data_idx = full_bits_q ? BIT_CNT_W'(DATA_WIDTH - 1) : BIT_CNT_W'(DATA_WIDTH - 2);
  assign last_stop_idx = BIT_CNT_W'(two_stop_q);
  assign frame_bad     = err_q | ~rx_s;
  assign busy_o        = (state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic and per-cycle sample/completion strobes.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    data_sample = 1'b0;
    stop_sample = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (baud_mid) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (baud_end) begin
          data_sample = 1'b1;
          if (bit_cnt == last_data_idx) state_next = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          stop_sample = 1'b1;
          if (bit_cnt == last_stop_idx) begin
            frame_done = 1'b1;
            state_next = frame_bad ? WAIT_HIGH : IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Disable overrides everything: drop the partial frame, emit nothing.
    if (!enable_i) begin
      state_next  = IDLE;
      start_frame = 1'b0;
      data_sample = 1'b0;
      stop_sample = 1'b0;
      frame_done  = 1'b0;
    end
  end

  // Frame configuration latched when a start edge is accepted.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      tick_q      <= '0;
      full_bits_q <= 1'b0;
      two_stop_q  <= 1'b0;
    end else if (start_frame) begin
      tick_q      <= baud_tick_val_i;
      full_bits_q <= data_bit_num_i;
      two_stop_q  <= stop_bit_num_i;
    end
  end

  // Baud counter: wraps at the divisor, restarts on every state entry.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i || !enable_i || state == IDLE || state_next != state) baud_cnt <= '0;
    else if (baud_end)                                                    baud_cnt <= '0;
    else                                                                  baud_cnt <= baud_cnt + 1'b1;
  end

  // Bit counter: counts data samples in DATA and stop samples in STOP.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i || !enable_i || state_next != state) bit_cnt <= '0;
    else if (data_sample || stop_sample)                bit_cnt <= bit_cnt + 1'b1;
  end

  // Shift register: LSB arrives first, so shift right inserting at the MSB.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i)       shreg <= '0;
    else if (data_sample) shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
  end

  // Sticky stop-bit error for the current frame.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i || start_frame)  err_q <= 1'b0;
    else if (stop_sample && !rx_s)  err_q <= 1'b1;
  end

  // Output word and mutually exclusive completion strobes. In short mode the
  // word sits in the upper bits of the shift register and is zero-extended.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      data_valid_o <= frame_done & ~frame_bad;
      frame_err_o  <= frame_done &  frame_bad;
      if (frame_done)
        data_o <= full_bits_q ? shreg : {1'b0, shreg[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: one task per scenario, inline checks.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int BW = 9;

  logic          clk = 1'b0;
  logic          s_rst_n;
  logic          enable;
  logic          rx;
  logic          dbn;
  logic          sbn;
  logic [BW-1:0] btv;
  logic [DW-1:0] data;
  logic          dv;
  logic          fe;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int P            = 16;
  int cyc          = 0;
  int start_cyc    = 0;
  int valid_cyc    = 0;
  int valid_cnt    = 0;
  int err_cnt      = 0;
  int both_cnt     = 0;
  logic [DW-1:0] vq[$];

  uart_rx #(
    .DATA_WIDTH(DW),
    .BAUD_GEN_CNTER_MAX_VAL(512)
  ) dut (
    .clk_i(clk),
    .s_rst_n_i(s_rst_n),
    .enable_i(enable),
    .rx_i(rx),
    .data_bit_num_i(dbn),
    .stop_bit_num_i(sbn),
    .baud_tick_val_i(btv),
    .data_o(data),
    .data_valid_o(dv),
    .frame_err_o(fe),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe observer, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (dv) begin
      valid_cnt++;
      valid_cyc = cyc;
      vq.push_back(data);
    end
    if (fe) err_cnt++;
    if (dv && fe) both_cnt++;
  end

  task automatic clear_obs();
    valid_cnt = 0;
    err_cnt   = 0;
    vq.delete();
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input int nstops, input logic stop_val);
    start_cyc = cyc;
    drive_bit(1'b0, P);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], P);
    for (int s = 0; s < nstops; s++) drive_bit(stop_val, P);
  endtask

  task automatic test_reset();
    logic busy_bad;
    s_rst_n = 1'b0;
    enable  = 1'b1;
    rx      = 1'b0;
    dbn     = 1'b1;
    sbn     = 1'b0;
    btv     = 9'd15;
    repeat (5) @(negedge clk);
    tests_run++;
    if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h expected 0", data); end
    tests_run++;
    if (dv !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", dv); end
    tests_run++;
    if (fe !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b expected 0", fe); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rx       = 1'b1;
    s_rst_n  = 1'b1;
    busy_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_bad = 1'b1;
    end
    tests_run++;
    if (busy_bad !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got busy high expected 0"); end
  endtask

  task automatic test_basic();
    int lat;
    P = 16; btv = 9'd15; dbn = 1'b1; sbn = 1'b0;
    clear_obs();
    send_frame(8'hA5, 8, 1, 1'b1);
    idle(20);
    lat = valid_cyc - start_cyc;
    tests_run++;
    if (valid_cnt != 1) begin tests_failed++; $display("FAIL basic_valid_cnt: got %0d expected 1", valid_cnt); end
    tests_run++;
    if (err_cnt != 0) begin tests_failed++; $display("FAIL basic_err_cnt: got %0d expected 0", err_cnt); end
    tests_run++;
    if (data !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %0h expected a5", data); end
    tests_run++;
    if (lat < 153 || lat > 155) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 153..155", lat); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w0, w1;
    dbn = 1'b0; sbn = 1'b1;
    clear_obs();
    send_frame(8'h7F, 7, 2, 1'b1);
    send_frame(8'h15, 7, 2, 1'b1);
    idle(20);
    w0 = (vq.size() > 0) ? vq[0] : 8'hxx;
    w1 = (vq.size() > 1) ? vq[1] : 8'hxx;
    tests_run++;
    if (valid_cnt != 2) begin tests_failed++; $display("FAIL b2b_valid_cnt: got %0d expected 2", valid_cnt); end
    tests_run++;
    if (w0 !== 8'h7F) begin tests_failed++; $display("FAIL b2b_word0: got %0h expected 7f", w0); end
    tests_run++;
    if (w1 !== 8'h15) begin tests_failed++; $display("FAIL b2b_word1: got %0h expected 15", w1); end
    tests_run++;
    if (data[7] !== 1'b0) begin tests_failed++; $display("FAIL b2b_msb: got %b expected 0", data[7]); end
    tests_run++;
    if (err_cnt != 0) begin tests_failed++; $display("FAIL b2b_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_frame_err();
    logic busy_dropped;
    dbn = 1'b1; sbn = 1'b0;
    clear_obs();
    send_frame(8'h3C, 8, 1, 1'b0);
    busy_dropped = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_dropped = 1'b1;
    end
    idle(10);
    tests_run++;
    if (err_cnt != 1) begin tests_failed++; $display("FAIL ferr_err_cnt: got %0d expected 1", err_cnt); end
    tests_run++;
    if (valid_cnt != 0) begin tests_failed++; $display("FAIL ferr_valid_cnt: got %0d expected 0", valid_cnt); end
    tests_run++;
    if (data !== 8'h3C) begin tests_failed++; $display("FAIL ferr_data: got %0h expected 3c", data); end
    tests_run++;
    if (busy_dropped !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy_low_line: got busy low expected high"); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy_after_rise: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    logic [DW-1:0] prev;
    logic busy_seen;
    prev = data;
    clear_obs();
    busy_seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    tests_run++;
    if (busy_seen !== 1'b1) begin tests_failed++; $display("FAIL glitch_start_seen: got no busy expected busy"); end
    tests_run++;
    if (valid_cnt != 0) begin tests_failed++; $display("FAIL glitch_valid_cnt: got %0d expected 0", valid_cnt); end
    tests_run++;
    if (err_cnt != 0) begin tests_failed++; $display("FAIL glitch_err_cnt: got %0d expected 0", err_cnt); end
    tests_run++;
    if (data !== prev) begin tests_failed++; $display("FAIL glitch_data: got %0h expected %0h", data, prev); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy: got %b expected 0", busy); end
  endtask

  task automatic test_enable_abort();
    logic [7:0] d;
    logic busy_at_disable;
    dbn = 1'b1; sbn = 1'b0;
    d = 8'h5A;
    clear_obs();
    drive_bit(1'b0, P);
    for (int i = 0; i < 4; i++) drive_bit(d[i], P);
    drive_bit(d[4], 8);
    enable = 1'b0;
    drive_bit(d[4], 2);
    busy_at_disable = busy;
    drive_bit(d[4], 6);
    for (int i = 5; i < 8; i++) drive_bit(d[i], P);
    drive_bit(1'b1, P);
    idle(10);
    enable = 1'b1;
    idle(10);
    send_frame(8'h81, 8, 1, 1'b1);
    idle(20);
    tests_run++;
    if (busy_at_disable !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b expected 0", busy_at_disable); end
    tests_run++;
    if (valid_cnt != 1) begin tests_failed++; $display("FAIL abort_valid_cnt: got %0d expected 1", valid_cnt); end
    tests_run++;
    if (err_cnt != 0) begin tests_failed++; $display("FAIL abort_err_cnt: got %0d expected 0", err_cnt); end
    tests_run++;
    if (data !== 8'h81) begin tests_failed++; $display("FAIL abort_data: got %0h expected 81", data); end
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (both_cnt != 0) begin tests_failed++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask

  initial begin
    s_rst_n = 1'b0;
    enable  = 1'b1;
    rx      = 1'b1;
    dbn     = 1'b1;
    sbn     = 1'b0;
    btv     = 9'd15;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_enable_abort();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
